// File: rtl/spmv_pkg.sv
// Shared types and entry layout for the SpMV row accumulator.
// An entry is packed MSB first as {last, row, col, val}.
package spmv_pkg;

  localparam int SPMV_DATA_W  = 16;
  localparam int SPMV_ROW_W   = 8;
  localparam int SPMV_COL_W   = 8;
  localparam int SPMV_ACC_W   = 40;

  localparam int VAL_LSB      = 0;
  localparam int COL_LSB      = VAL_LSB + SPMV_DATA_W;
  localparam int ROW_LSB      = COL_LSB + SPMV_COL_W;
  localparam int LAST_BIT     = ROW_LSB + SPMV_ROW_W;
  localparam int SPMV_ENTRY_W = LAST_BIT + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_XRD,
    ST_MAC,
    ST_EMIT,
    ST_DONE
  } acc_state_t;

  typedef enum logic [1:0] {
    MAC_NOP,
    MAC_START,
    MAC_ADD,
    MAC_LOAD
  } mac_op_t;

  typedef struct packed {
    logic                          last;
    logic [SPMV_ROW_W-1:0]         row;
    logic [SPMV_COL_W-1:0]         col;
    logic signed [SPMV_DATA_W-1:0] val;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [SPMV_ENTRY_W-1:0] raw);
    entry_t e;
    e.last = raw[LAST_BIT];
    e.row  = raw[ROW_LSB +: SPMV_ROW_W];
    e.col  = raw[COL_LSB +: SPMV_COL_W];
    e.val  = raw[VAL_LSB +: SPMV_DATA_W];
    return e;
  endfunction

endpackage

// File: rtl/spmv_row_accumulator_if.sv
// FIFO read, vector RAM read and result handshake bundle of the row accumulator.
// master = accumulator side, slave = FIFO / RAM / result consumer side.
interface spmv_row_accumulator_if #(
  parameter int ACC_W = spmv_pkg::SPMV_ACC_W
);
  logic                                   start;
  logic                                   fifo_empty;
  logic                                   fifo_en;
  logic                                   fifo_rw;
  logic [spmv_pkg::SPMV_ENTRY_W-1:0]      fifo_rdata;
  logic [spmv_pkg::SPMV_COL_W-1:0]        x_addr;
  logic signed [spmv_pkg::SPMV_DATA_W-1:0] x_data;
  logic                                   y_valid;
  logic                                   y_ready;
  logic [spmv_pkg::SPMV_ROW_W-1:0]        y_row;
  logic signed [ACC_W-1:0]                y_data;
  logic                                   busy;
  logic                                   done;

  modport master (
    input  start, fifo_empty, fifo_rdata, x_data, y_ready,
    output fifo_en, fifo_rw, x_addr, y_valid, y_row, y_data, busy, done
  );

  modport slave (
    output start, fifo_empty, fifo_rdata, x_data, y_ready,
    input  fifo_en, fifo_rw, x_addr, y_valid, y_row, y_data, busy, done
  );
endinterface

// File: rtl/spmv_mac_unit.sv
// Registered signed multiply with an ACC_W accumulator that can start, add, or
// reload from the previously registered product (used when a new row begins).
module spmv_mac_unit
  import spmv_pkg::*;
#(
  parameter int DATA_W = SPMV_DATA_W,
  parameter int ACC_W  = SPMV_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  mac_op_t                  op_i,
  input  logic                     mul_en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  prod_d, prod_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  assign prod     = PROD_W'(a_i) * PROD_W'(b_i);
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    if (mul_en_i) prod_d = prod_ext;
    case (op_i)
      MAC_START: acc_d = prod_ext;
      MAC_ADD:   acc_d = acc_q + prod_ext;
      MAC_LOAD:  acc_d = prod_q;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/spmv_row_accumulator.sv
// Sparse row accumulator: pops entries, multiplies val*x[col], emits one (row, sum) per row group.
// Flow: IDLE -> POP -> WAIT -> XRD -> MAC -> (POP | EMIT) ... EMIT -> DONE -> IDLE.
module spmv_row_accumulator
  import spmv_pkg::*;
#(
  parameter int ACC_W  = SPMV_ACC_W,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  spmv_row_accumulator_if.master bus
);
  localparam int DATA_W = SPMV_DATA_W;
  localparam int ROW_W  = SPMV_ROW_W;
  localparam int COL_W  = SPMV_COL_W;
  localparam int CNT_W  = $clog2(RD_LAT + 1);

  acc_state_t               state_q;
  logic [CNT_W-1:0]         wait_cnt_q;
  logic                     e_last_q;
  logic [ROW_W-1:0]         e_row_q;
  logic signed [DATA_W-1:0] e_val_q;
  logic [ROW_W-1:0]         cur_row_q;
  logic                     acc_valid_q;
  logic                     swap_pend_q;
  logic                     fifo_en_q;
  logic [COL_W-1:0]         x_addr_q;
  logic                     y_valid_q;
  logic                     busy_q;
  logic                     done_q;

  entry_t                   rd_ent;
  mac_op_t                  mac_op;
  logic                     mac_mul_en;
  logic signed [ACC_W-1:0]  acc;
  logic                     y_fire;

  assign rd_ent = unpack_entry(bus.fifo_rdata);
  assign y_fire = y_valid_q && bus.y_ready;

  always_comb begin
    mac_mul_en = (state_q == ST_MAC);
    mac_op     = MAC_NOP;
    if (state_q == ST_MAC) begin
      if (!acc_valid_q)               mac_op = MAC_START;
      else if (e_row_q == cur_row_q)  mac_op = MAC_ADD;
    end else if (state_q == ST_EMIT && y_fire && swap_pend_q) begin
      mac_op = MAC_LOAD;
    end
  end

  spmv_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .op_i     (mac_op),
    .mul_en_i (mac_mul_en),
    .a_i      (e_val_q),
    .b_i      (bus.x_data),
    .acc_o    (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      e_last_q    <= 1'b0;
      e_row_q     <= '0;
      e_val_q     <= '0;
      cur_row_q   <= '0;
      acc_valid_q <= 1'b0;
      swap_pend_q <= 1'b0;
      fifo_en_q   <= 1'b0;
      x_addr_q    <= '0;
      y_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fifo_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_POP;
            busy_q  <= 1'b1;
          end
        end
        ST_POP: begin
          // The strobe is registered, so one extra wait cycle keeps the capture RD_LAT after it.
          if (!bus.fifo_empty) begin
            fifo_en_q  <= 1'b1;
            wait_cnt_q <= CNT_W'(RD_LAT);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            e_last_q <= rd_ent.last;
            e_row_q  <= rd_ent.row;
            e_val_q  <= rd_ent.val;
            x_addr_q <= rd_ent.col;
            state_q  <= ST_XRD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_XRD: state_q <= ST_MAC;
        ST_MAC: begin
          if (!acc_valid_q || e_row_q == cur_row_q) begin
            cur_row_q   <= e_row_q;
            acc_valid_q <= 1'b1;
            if (e_last_q) begin
              y_valid_q <= 1'b1;
              state_q   <= ST_EMIT;
            end else begin
              state_q <= ST_POP;
            end
          end else begin
            swap_pend_q <= 1'b1;
            y_valid_q   <= 1'b1;
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (y_fire) begin
            if (swap_pend_q) begin
              cur_row_q   <= e_row_q;
              swap_pend_q <= 1'b0;
              if (!e_last_q) begin
                y_valid_q <= 1'b0;
                state_q   <= ST_POP;
              end
            end else begin
              acc_valid_q <= 1'b0;
              y_valid_q   <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_en = fifo_en_q;
  assign bus.fifo_rw = 1'b0;
  assign bus.x_addr  = x_addr_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_row   = cur_row_q;
  assign bus.y_data  = acc;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Directed bench for spmv_row_accumulator with a latency-accurate FIFO and vector RAM model.
module tb_spmv_row_accumulator;
  import spmv_pkg::*;

  localparam int ACC_W  = 40;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spmv_row_accumulator_if #(.ACC_W(ACC_W)) bus ();

  spmv_row_accumulator #(.ACC_W(ACC_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_pop = 0;
  int n_en_empty = 0;
  int n_done = 0;

  logic [SPMV_ENTRY_W-1:0]         fq[$];
  logic [SPMV_ENTRY_W-1:0]         rd_ent;
  int                              rd_cnt = -1;
  logic signed [SPMV_DATA_W-1:0]   xmem [256];
  logic [SPMV_ROW_W-1:0]           yrow_q[$];
  logic signed [ACC_W-1:0]         ydat_q[$];

  // FIFO: request seen at an edge, data presented for one cycle RD_LAT cycles after the strobe.
  always @(posedge clk) begin
    logic en_s, empty_s;
    en_s    = bus.fifo_en;
    empty_s = bus.fifo_empty;
    if (en_s) n_pop++;
    if (en_s && empty_s) n_en_empty++;
    #1;
    bus.fifo_rdata = {SPMV_ENTRY_W{1'b1}};
    if (rd_cnt == 0) bus.fifo_rdata = rd_ent;
    if (rd_cnt >= 0) rd_cnt--;
    if (en_s && fq.size() > 0) begin
      rd_ent = fq.pop_front();
      rd_cnt = RD_LAT - 2;
    end
    bus.fifo_empty = (fq.size() == 0);
  end

  always @(posedge clk) begin
    logic [SPMV_COL_W-1:0] a;
    a = bus.x_addr;
    #1;
    bus.x_data = xmem[a];
  end

  always @(posedge clk) begin
    if (bus.y_valid && bus.y_ready) begin
      yrow_q.push_back(bus.y_row);
      ydat_q.push_back(bus.y_data);
    end
    if (bus.done) n_done++;
  end

  function automatic logic [SPMV_ENTRY_W-1:0] mk(input int last, input int row, input int col, input int val);
    return {last != 0, 8'(row), 8'(col), 16'(val)};
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_y(input string tag, input int row, input longint data);
    logic signed [63:0] r, d;
    r = 'x;
    d = 'x;
    if (yrow_q.size() > 0) begin
      r = 64'(yrow_q.pop_front());
      d = 64'(ydat_q.pop_front());
    end
    chk({tag, "_row"}, r, row);
    chk({tag, "_data"}, d, data);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c, d0;
    c  = 0;
    d0 = n_done;
    while (n_done == d0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, 64'(n_done - d0), 1);
  endtask

  initial begin
    int c, p0, p1, d0, stable, busy_ok;
    logic [SPMV_ROW_W-1:0]   r0;
    logic signed [ACC_W-1:0] v0;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.y_ready = 1'b1;
    for (int i = 0; i < 256; i++) xmem[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_fifo_en", 64'(bus.fifo_en), 0);
    chk("rst_fifo_rw", 64'(bus.fifo_rw), 0);
    chk("rst_x_addr",  64'(bus.x_addr), 0);
    chk("rst_y_valid", 64'(bus.y_valid), 0);
    chk("rst_y_row",   64'(bus.y_row), 0);
    chk("rst_y_data",  64'(bus.y_data), 0);
    chk("rst_busy",    64'(bus.busy), 0);
    chk("rst_done",    64'(bus.done), 0);
    reset = 1'b0;

    // Single row: 2*4 + 5*(-1) = 3
    xmem[0] = 16'sd4;
    xmem[1] = -16'sd1;
    fq.push_back(mk(0, 3, 0, 2));
    fq.push_back(mk(1, 3, 1, 5));
    pulse_start();
    chk("t1_busy", 64'(bus.busy), 1);
    wait_done("t1", 200);
    chk("t1_idle", 64'(bus.busy), 0);
    chk("t1_nres", 64'(yrow_q.size()), 1);
    expect_y("t1", 3, 3);

    // Two rows sharing x[2]=10
    xmem[2] = 16'sd10;
    fq.push_back(mk(0, 0, 2, 1));
    fq.push_back(mk(1, 1, 2, 7));
    pulse_start();
    wait_done("t2", 200);
    chk("t2_nres", 64'(yrow_q.size()), 2);
    expect_y("t2a", 0, 10);
    expect_y("t2b", 1, 70);

    // Backpressure on the row-change emit: row5 = 3*(-6) + (-2)*9 = -36, row6 = 4*(-6) = -24
    bus.y_ready = 1'b0;
    xmem[3] = -16'sd6;
    xmem[4] = 16'sd9;
    fq.push_back(mk(0, 5, 3, 3));
    fq.push_back(mk(0, 5, 4, -2));
    fq.push_back(mk(1, 6, 3, 4));
    pulse_start();
    c = 0;
    while (!bus.y_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t3_valid", 64'(bus.y_valid), 1);
    chk("t3_hold_row", 64'(bus.y_row), 5);
    chk("t3_hold_data", 64'(bus.y_data), -36);
    r0 = bus.y_row;
    v0 = bus.y_data;
    p0 = n_pop;
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.y_row !== r0 || bus.y_data !== v0 || bus.y_valid !== 1'b1) stable = 0;
    end
    chk("t3_stable", 64'(stable), 1);
    chk("t3_no_pop", 64'(n_pop - p0), 0);
    bus.y_ready = 1'b1;
    wait_done("t3", 200);
    chk("t3_nres", 64'(yrow_q.size()), 2);
    expect_y("t3a", 5, -36);
    expect_y("t3b", 6, -24);

    // Empty FIFO between entries: 3*11 + (-4)*7 = 5
    xmem[5] = 16'sd11;
    xmem[6] = 16'sd7;
    p0 = n_pop;
    fq.push_back(mk(0, 2, 5, 3));
    pulse_start();
    c = 0;
    while (n_pop == p0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t4_first_pop", 64'(n_pop - p0), 1);
    p1 = n_pop;
    busy_ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 0;
    end
    chk("t4_no_pop", 64'(n_pop - p1), 0);
    chk("t4_busy", 64'(busy_ok), 1);
    fq.push_back(mk(1, 2, 6, -4));
    wait_done("t4", 200);
    chk("t4_nres", 64'(yrow_q.size()), 1);
    expect_y("t4", 2, 5);

    // 300 * 32767^2 = 322102886700, fits in 40 bits
    xmem[8] = 16'sd32767;
    for (int i = 0; i < 300; i++) fq.push_back(mk(i == 299, 7, 8, 32767));
    pulse_start();
    wait_done("t5a", 5000);
    chk("t5a_nres", 64'(yrow_q.size()), 1);
    expect_y("t5a", 7, 64'sd322102886700);

    // 600 * 2^30 = 644245094400 wraps to 644245094400 - 2^40 = -455266533376
    xmem[9] = -16'sd32768;
    for (int i = 0; i < 600; i++) fq.push_back(mk(i == 599, 9, 9, -32768));
    pulse_start();
    wait_done("t5b", 9000);
    chk("t5b_nres", 64'(yrow_q.size()), 1);
    expect_y("t5b", 9, -64'sd455266533376);

    // Reset after two MACs of row 1 (acc = 3 + 5 = 8)
    xmem[10] = 16'sd3;
    xmem[11] = 16'sd5;
    xmem[12] = 16'sd9;
    p0 = n_pop;
    fq.push_back(mk(0, 1, 10, 1));
    fq.push_back(mk(0, 1, 11, 1));
    fq.push_back(mk(1, 1, 12, 1));
    pulse_start();
    c = 0;
    while (n_pop < p0 + 3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t6_third_pop", 64'(n_pop - p0), 3);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_fifo_en", 64'(bus.fifo_en), 0);
    chk("t6_x_addr",  64'(bus.x_addr), 0);
    chk("t6_y_valid", 64'(bus.y_valid), 0);
    chk("t6_y_row",   64'(bus.y_row), 0);
    chk("t6_y_data",  64'(bus.y_data), 0);
    chk("t6_busy",    64'(bus.busy), 0);
    chk("t6_done",    64'(bus.done), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_done", 64'(n_done - d0), 0);
    chk("t6_no_res", 64'(yrow_q.size()), 0);
    fq.delete();
    // Fresh matrix: 3*100 + (-5)*20 = 200
    xmem[13] = 16'sd100;
    xmem[14] = 16'sd20;
    fq.push_back(mk(0, 4, 13, 3));
    fq.push_back(mk(1, 4, 14, -5));
    pulse_start();
    wait_done("t6", 200);
    chk("t6_nres", 64'(yrow_q.size()), 1);
    expect_y("t6", 4, 200);

    chk("en_while_empty", 64'(n_en_empty), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
